// File: rtl/board_scan_gen_if.sv
// Signal bundle between the VGA scan generator and the per-block renderer.
// The generator (master) drives raster timing, decoded board coordinates and
// the frame-stable board map; the renderer side (slave) supplies the live map.
interface board_scan_gen_if;
  logic [124:0] map_in;
  logic [124:0] map_frame;
  logic         hsync;
  logic         vsync;
  logic         active;
  logic         in_board;
  logic [9:0]   h_cnt;
  logic [9:0]   v_cnt;
  logic [2:0]   block_x;
  logic [2:0]   block_y;
  logic [5:0]   pixel_x;
  logic [5:0]   pixel_y;
  logic         frame_start;

  modport master (
    input  map_in,
    output map_frame, hsync, vsync, active, in_board, h_cnt, v_cnt,
           block_x, block_y, pixel_x, pixel_y, frame_start
  );

  modport slave (
    output map_in,
    input  map_frame, hsync, vsync, active, in_board, h_cnt, v_cnt,
           block_x, block_y, pixel_x, pixel_y, frame_start
  );
endinterface

// File: rtl/board_scan_gen.sv
// VGA raster generator for the 5x5 Bingo board (64x64-pixel blocks).
// Produces registered, mutually aligned timing and board coordinates one
// cycle after the raster counters, and snapshots the board map on the first
// vertical-blanking line so a frame is always drawn from one consistent map.
module board_scan_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int BOARD_X0 = 160,
  parameter int BOARD_Y0 = 80
) (
  input  logic              clk_25MHz,
  input  logic              all_rst,
  board_scan_gen_if.master  bus
);

  localparam int BOARD_PIX = 5 * 64;
  localparam int H_TOT     = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT     = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] BX_BEG = 10'(BOARD_X0);
  localparam logic [9:0] BX_END = 10'(BOARD_X0 + BOARD_PIX);
  localparam logic [9:0] BY_BEG = 10'(BOARD_Y0);
  localparam logic [9:0] BY_END = 10'(BOARD_Y0 + BOARD_PIX);
  // The board spans fewer than 512 pixels, so offsets fit in 9 bits.
  localparam logic [8:0] BX_OFF = 9'(BOARD_X0);
  localparam logic [8:0] BY_OFF = 9'(BOARD_Y0);

  // Everything the renderer consumes in a given pixel cycle.
  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       active;
    logic       in_board;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic [2:0] block_x;
    logic [2:0] block_y;
    logic [5:0] pixel_x;
    logic [5:0] pixel_y;
    logic       frame_start;
  } scan_t;

  localparam scan_t SCAN_RST = '{hsync: 1'b1, vsync: 1'b1, default: '0};

  logic [9:0]   hc_q, hc_d;
  logic [9:0]   vc_q, vc_d;
  scan_t        scan_q, scan_d;
  logic [124:0] map_frame_q, map_frame_d;

  logic [8:0]   dx, dy;
  logic         in_board_w;

  // Raster counters: advance one pixel per cycle, wrap at line and frame end.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no branch can
    // leave a value unassigned and infer a latch.
    hc_d = hc_q + 10'd1;
    vc_d = vc_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
    end
  end

  // Decode the current raster position into sync, visibility and board coords.
  always_comb begin
    dx         = hc_q[8:0] - BX_OFF;
    dy         = vc_q[8:0] - BY_OFF;
    in_board_w = (hc_q >= BX_BEG) && (hc_q < BX_END) &&
                 (vc_q >= BY_BEG) && (vc_q < BY_END);

    scan_d             = SCAN_RST;
    scan_d.h_cnt       = hc_q;
    scan_d.v_cnt       = vc_q;
    scan_d.active      = (hc_q < H_ACT) && (vc_q < V_ACT);
    scan_d.hsync       = !((hc_q >= HS_BEG) && (hc_q < HS_END));
    scan_d.vsync       = !((vc_q >= VS_BEG) && (vc_q < VS_END));
    scan_d.in_board    = in_board_w;
    scan_d.frame_start = (hc_q == '0) && (vc_q == '0);
    if (in_board_w) begin
      scan_d.block_x = dx[8:6];
      scan_d.pixel_x = dx[5:0];
      scan_d.block_y = dy[8:6];
      scan_d.pixel_y = dy[5:0];
    end
  end

  // Snapshot the live map at the start of vertical blanking; hold otherwise.
  always_comb begin
    map_frame_d = map_frame_q;
    if ((hc_q == '0) && (vc_q == V_ACT)) begin
      map_frame_d = bus.map_in;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_25MHz) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order.
    if (all_rst) begin
      hc_q        <= '0;
      vc_q        <= '0;
      scan_q      <= SCAN_RST;
      // NOTE: the map snapshot is a plain register bank, not a memory, so it
      // is reset: the renderer shows an empty board until the first latch.
      map_frame_q <= '0;
    end else begin
      hc_q        <= hc_d;
      vc_q        <= vc_d;
      scan_q      <= scan_d;
      map_frame_q <= map_frame_d;
    end
  end

  assign bus.map_frame   = map_frame_q;
  assign bus.hsync       = scan_q.hsync;
  assign bus.vsync       = scan_q.vsync;
  assign bus.active      = scan_q.active;
  assign bus.in_board    = scan_q.in_board;
  assign bus.h_cnt       = scan_q.h_cnt;
  assign bus.v_cnt       = scan_q.v_cnt;
  assign bus.block_x     = scan_q.block_x;
  assign bus.block_y     = scan_q.block_y;
  assign bus.pixel_x     = scan_q.pixel_x;
  assign bus.pixel_y     = scan_q.pixel_y;
  assign bus.frame_start = scan_q.frame_start;

endmodule

// File: tb/tb_board_scan_gen.sv
// Bench for board_scan_gen at default 640x480@60 timing. A reference raster
// model pushes the expected output of every edge into a queue that is popped
// and compared on the falling edge; table-driven position vectors and short
// hand-written sequences cover the boundaries, map latch, wrap and reset.
module tb_board_scan_gen;

  logic clk_25MHz = 1'b0;
  logic all_rst   = 1'b1;

  board_scan_gen_if bus ();

  board_scan_gen dut (
    .clk_25MHz (clk_25MHz),
    .all_rst   (all_rst),
    .bus       (bus.master)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  localparam int FRAME = 800 * 525;
  localparam int WAIT_MAX = FRAME + 16;
  localparam logic [124:0] MAP_A = {5{25'h15A5A5A}};
  localparam logic [124:0] MAP_B = {5{25'h0C3F0F3}};
  localparam logic [124:0] MAP_C = ~MAP_A;

  typedef struct packed {
    logic [124:0] map;
    logic         hs, vs, act, inb, fs;
    logic [9:0]   h, v;
    logic [2:0]   bx, by;
    logic [5:0]   px, py;
  } obs_t;

  localparam obs_t OBS_RST = '{hs: 1'b1, vs: 1'b1, default: '0};

  typedef struct {
    int         h, v;
    logic       act, inb, hs, vs, fs;
    logic [2:0] bx, by;
    logic [5:0] px, py;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Scoreboard state
  obs_t        sb_q[$];
  int unsigned sb_edge_q[$];
  int          m_hc = 0, m_vc = 0, m_edge = 0;
  logic [124:0] m_map = '0;
  int          stream_err = 0;
  bit          stat_on = 1'b1;
  int          fs_cnt = 0, hs_low = 0, vs_low = 0;

  task automatic check(input string name, input logic [159:0] act,
                       input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic obs_t dut_obs();
    obs_t o;
    o.map = bus.map_frame; o.hs = bus.hsync; o.vs = bus.vsync;
    o.act = bus.active; o.inb = bus.in_board; o.fs = bus.frame_start;
    o.h = bus.h_cnt; o.v = bus.v_cnt;
    o.bx = bus.block_x; o.by = bus.block_y;
    o.px = bus.pixel_x; o.py = bus.pixel_y;
    return o;
  endfunction

  // Reference decode written with plain arithmetic on the default geometry.
  function automatic obs_t model_pos(input int h, input int v,
                                     input logic [124:0] map);
    obs_t o;
    o     = '0;
    o.map = map;
    o.h   = 10'(h);
    o.v   = 10'(v);
    o.act = (h < 640) && (v < 480);
    o.hs  = !(h >= 656 && h < 752);
    o.vs  = !(v >= 490 && v < 492);
    o.fs  = (h == 0) && (v == 0);
    o.inb = (h >= 160) && (h < 480) && (v >= 80) && (v < 400);
    if (o.inb) begin
      o.bx = 3'((h - 160) / 64);
      o.px = 6'((h - 160) % 64);
      o.by = 3'((v - 80) / 64);
      o.py = 6'((v - 80) % 64);
    end
    return o;
  endfunction

  // Reference model: push the expected output of each edge.
  always @(posedge clk_25MHz) begin
    obs_t e;
    int nh, nv, ne;
    logic [124:0] nm;
    if (all_rst) begin
      e = OBS_RST; nh = 0; nv = 0; nm = '0; ne = 0;
    end else begin
      nm = (m_hc == 0 && m_vc == 480) ? bus.map_in : m_map;
      e  = model_pos(m_hc, m_vc, nm);
      ne = m_edge + 1;
      nh = m_hc + 1;
      nv = m_vc;
      if (nh == 800) begin
        nh = 0;
        nv = (m_vc == 524) ? 0 : m_vc + 1;
      end
    end
    sb_q.push_back(e);
    sb_edge_q.push_back(ne);
    m_hc   <= nh;
    m_vc   <= nv;
    m_map  <= nm;
    m_edge <= ne;
  end

  // Monitor: pop and compare every cycle, gather per-frame sync statistics.
  always @(negedge clk_25MHz) begin
    obs_t e, a;
    int unsigned en;
    if (sb_q.size() > 0) begin
      e  = sb_q.pop_front();
      en = sb_edge_q.pop_front();
      a  = dut_obs();
      if (a !== e) begin
        if (stream_err == 0)
          $display("first divergence at edge %0d: dut=%h model=%h", en, a, e);
        stream_err <= stream_err + 1;
      end
      if (stat_on && en >= 1) begin
        if (en <= FRAME + 1 && a.fs) fs_cnt <= fs_cnt + 1;
        if (en <= FRAME) begin
          if (!a.hs) hs_low <= hs_low + 1;
          if (!a.vs) vs_low <= vs_low + 1;
        end
      end
    end
  end

  task automatic wait_pos(input int h, input int v, input string name,
                          output bit ok);
    ok = 1'b0;
    for (int i = 0; i < WAIT_MAX; i++) begin
      @(negedge clk_25MHz);
      if (bus.h_cnt == 10'(h) && bus.v_cnt == 10'(v)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s: position (%0d,%0d) not reached within %0d cycles",
               name, h, v, WAIT_MAX);
    end
  endtask

  vec_t vecs[$];

  initial begin
    bit ok;
    bus.map_in = MAP_A;

    //            h    v   act inb hs vs fs bx by px  py
    vecs.push_back('{655,  10, 0, 0, 1, 1, 0, 0, 0,  0,  0});
    vecs.push_back('{656,  10, 0, 0, 0, 1, 0, 0, 0,  0,  0});
    vecs.push_back('{751,  10, 0, 0, 0, 1, 0, 0, 0,  0,  0});
    vecs.push_back('{752,  10, 0, 0, 1, 1, 0, 0, 0,  0,  0});
    vecs.push_back('{159,  80, 1, 0, 1, 1, 0, 0, 0,  0,  0});
    vecs.push_back('{160,  80, 1, 1, 1, 1, 0, 0, 0,  0,  0});
    vecs.push_back('{224, 143, 1, 1, 1, 1, 0, 1, 0,  0, 63});
    vecs.push_back('{479, 399, 1, 1, 1, 1, 0, 4, 4, 63, 63});
    vecs.push_back('{480, 399, 1, 0, 1, 1, 0, 0, 0,  0,  0});
    vecs.push_back('{639, 479, 1, 0, 1, 1, 0, 0, 0,  0,  0});
    vecs.push_back('{  0, 480, 0, 0, 1, 1, 0, 0, 0,  0,  0});
    vecs.push_back('{  0, 489, 0, 0, 1, 1, 0, 0, 0,  0,  0});
    vecs.push_back('{  0, 490, 0, 0, 1, 0, 0, 0, 0,  0,  0});
    vecs.push_back('{799, 491, 0, 0, 1, 0, 0, 0, 0,  0,  0});
    vecs.push_back('{  0, 492, 0, 0, 1, 1, 0, 0, 0,  0,  0});

    // Reset state
    repeat (3) @(negedge clk_25MHz);
    check("reset_state", dut_obs(), OBS_RST);
    all_rst = 1'b0;

    // First edge after release describes (0,0)
    @(negedge clk_25MHz);
    check("first_edge", {bus.h_cnt, bus.v_cnt, bus.frame_start},
          {10'd0, 10'd0, 1'b1});

    // Position vectors across frame 1
    foreach (vecs[i]) begin
      wait_pos(vecs[i].h, vecs[i].v, "vec_wait", ok);
      if (ok)
        check($sformatf("pos(%0d,%0d)", vecs[i].h, vecs[i].v),
              {bus.active, bus.in_board, bus.hsync, bus.vsync,
               bus.frame_start, bus.block_x, bus.block_y,
               bus.pixel_x, bus.pixel_y},
              {vecs[i].act, vecs[i].inb, vecs[i].hs, vecs[i].vs,
               vecs[i].fs, vecs[i].bx, vecs[i].by,
               vecs[i].px, vecs[i].py});
    end

    // Frame wrap
    wait_pos(799, 524, "wrap_wait", ok);
    if (ok) begin
      check("map_after_frame1", bus.map_frame, MAP_A);
      @(negedge clk_25MHz);
      check("wrap_to_origin", {bus.h_cnt, bus.v_cnt, bus.frame_start},
            {10'd0, 10'd0, 1'b1});
    end
    @(negedge clk_25MHz);
    stat_on = 1'b0;
    check("frame_start_count", fs_cnt, 2);
    check("hsync_low_cycles", hs_low, 96 * 525);
    check("vsync_low_cycles", vs_low, 1600);

    // Map change mid-frame is deferred to the blanking latch
    wait_pos(0, 10, "map_b_wait", ok);
    bus.map_in = MAP_B;
    check("map_hold_line10", bus.map_frame, MAP_A);
    wait_pos(799, 479, "map_pre_latch", ok);
    if (ok) check("map_hold_pre_latch", bus.map_frame, MAP_A);
    @(negedge clk_25MHz);
    check("map_latch", {bus.h_cnt, bus.v_cnt, bus.map_frame},
          {10'd0, 10'd480, MAP_B});
    @(negedge clk_25MHz);
    bus.map_in = MAP_C;
    wait_pos(799, 524, "map_c_wait", ok);
    if (ok) check("map_ignore_late_change", bus.map_frame, MAP_B);

    // Mid-frame reset
    wait_pos(300, 200, "reset_wait", ok);
    all_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_25MHz);
      check($sformatf("reset_hold_%0d", i), dut_obs(), OBS_RST);
    end
    all_rst = 1'b0;
    @(negedge clk_25MHz);
    check("restart_origin",
          {bus.h_cnt, bus.v_cnt, bus.frame_start, bus.map_frame},
          {10'd0, 10'd0, 1'b1, 125'd0});
    wait_pos(0, 100, "post_reset_wait", ok);
    if (ok) check("map_cleared_until_latch", bus.map_frame, 125'd0);

    repeat (2) @(negedge clk_25MHz);
    check("scoreboard_stream", stream_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/board_scan_gen.md
Name: board_scan_gen

Overview:
- Upstream stage of the per-block renderer. Generates 640x480@60 VGA timing from `clk_25MHz`.
- Decomposes the raster position into `block_x`/`block_y`/`pixel_x`/`pixel_y` for the 5x5 Bingo board. Each block is 64x64 pixels.
- Latches the 125-bit board map once per frame during vertical blanking, so the renderer never sees a map change mid-frame (no tearing).
- All outputs are registered and mutually aligned. The downstream colour mux consumes them in the same cycle.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- BOARD_X0, 160, first horizontal pixel of the board
- BOARD_Y0, 80, first line of the board

Ports:
- clk_25MHz  input  1  pixel clock
- all_rst  input  1  reset, synchronous, active-high
- map_in  input  125  live board map, 5 bits per cell, cell index = x + 5*y
- map_frame  output  125  map latched for the current frame
- hsync  output  1  horizontal sync, active-low
- vsync  output  1  vertical sync, active-low
- active  output  1  position inside the 640x480 visible area
- in_board  output  1  position inside the 320x320 board
- h_cnt  output  10  horizontal position
- v_cnt  output  10  vertical position
- block_x  output  3  board column, 0..4
- block_y  output  3  board row, 0..4
- pixel_x  output  6  x offset inside the block, 0..63
- pixel_y  output  6  y offset inside the block, 0..63
- frame_start  output  1  one-cycle pulse at position (0,0)

Behaviour:
- Line length H_TOT = 800 (sum of H params). Frame height V_TOT = 525 (sum of V params).
- Internal counters `hc` (10 bits) and `vc` (10 bits). Reset loads 0 into both.
  - Each non-reset edge: `hc` <= `hc`+1.
  - When `hc`==H_TOT-1: `hc` <= 0, `vc` <= `vc`+1.
  - When additionally `vc`==V_TOT-1: `vc` <= 0.
  - Both counters are always within 0..799 and 0..524.
- All outputs are registered from decode(`hc`,`vc`), latency 1. After the first non-reset edge, outputs describe position (0,0) and `hc`=1.
- Decode rules:
  - `h_cnt`/`v_cnt` = `hc`/`vc`.
  - `active` = `hc`<640 and `vc`<480.
  - `hsync` = 0 iff 656<=`hc`<752.
  - `vsync` = 0 iff 490<=`vc`<492.
  - `in_board` = 160<=`hc`<480 and 80<=`vc`<400, i.e. BOARD_X0..+319 and BOARD_Y0..+319.
  - When `in_board`: `dx`=`hc`-BOARD_X0, `dy`=`vc`-BOARD_Y0; `block_x`=`dx`[8:6], `pixel_x`=`dx`[5:0]; `block_y` and `pixel_y` are taken from `dy` the same way.
  - When not `in_board`: `block_x`, `block_y`, `pixel_x`, `pixel_y` are all 0.
  - `frame_start` = 1 iff `hc`==0 and `vc`==0.
- Map latch: `map_frame` <= `map_in` on the edge where `hc`==0 and `vc`==V_ACTIVE, i.e. the first blanking line. It holds at all other times. `map_in` changes at any other time have no visible effect until the next latch.
- Reset values:
  - `hsync`=1, `vsync`=1.
  - `map_frame`=0.
  - All other outputs 0.
- Reset asserted mid-frame: the next edge forces reset values. Counting restarts from (0,0) on the first edge after release, with no partial-line artifacts.
- Parameters may be overridden. Block size is fixed at 64 and the board at 5x5. BOARD_X0+320<=H_ACTIVE and BOARD_Y0+320<=V_ACTIVE are required.

Test Plan:
- Reset, then run 800*525 cycles:
  - `frame_start` pulses exactly twice: first edge after release, and edge 420001.
  - `hsync` is low 96 cycles per line.
  - `vsync` is low for 1600 cycles per frame.
- Position `hc`=159,`vc`=80 gives `in_board`=0 and all coords 0.
- Position `hc`=160,`vc`=80 gives `in_board`=1, blocks (0,0), pixels (0,0).
- Position `hc`=224,`vc`=143 gives `block_x`=1, `pixel_x`=0, `block_y`=0, `pixel_y`=63.
- Position `hc`=479,`vc`=399 gives block (4,4), pixel (63,63).
- Position `hc`=480 gives `in_board`=0.
- Map latch:
  - Set `map_in`=A, run to line 480.
  - Change to B at line 10 of the next frame: `map_frame` stays A until (0,480), then becomes B exactly one edge after.
- Wrap check: at `hc`=799,`vc`=524, the next output shows (0,0) with `frame_start`=1.
- Mid-frame reset at `hc`=300,`vc`=200 for 3 cycles:
  - Outputs show reset values while reset is held.
  - First edge after release shows (0,0).
  - `map_frame`=0 until the next latch.
